// File: rtl/step_pkg.sv
// ---------------------------------------------------------------------------
// step_pkg
// Shared definitions for the step controller: the sequencer FSM state
// encoding, the default data width carried through the step chain, and a
// helper that sizes step index fields.
// ---------------------------------------------------------------------------
package step_pkg;

  // Default width of the data word passed from step to step.
  localparam int STEP_DATA_W = 8;

  // Sequencer states: idle, one-cycle start pulse, wait for the step's done.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } step_state_t;

  // Width of a step index field; a single step still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_watchdog.sv
// ---------------------------------------------------------------------------
// step_watchdog
// Per-step wait counter. It is cleared while a step is being started and
// counts every done-less WAIT cycle afterwards. 'expired' is high when the
// current WAIT edge is the TIMEOUT-th consecutive one without an answer.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   clr     - clear the counter (sequencer is issuing a start)
//   en      - count one done-less WAIT cycle
//   expired - the step has used up its wait budget on this edge
// ---------------------------------------------------------------------------
module step_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clear wins over counting; the counter saturates at TIMEOUT so it can
  // never wrap back to a value that looks like a fresh wait.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The count holds the number of earlier done-less WAIT edges, so reaching
  // TIMEOUT-1 means this edge is the last one allowed.
  assign expired = (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
// Initiator side of the step start/done handshake. A job word accepted in
// IDLE is passed through NUM_STEPS step modules in index order: each step
// gets a one-cycle start pulse with the current data, and its output is
// latched as input for the next step once it reports done. After the last
// step the result is presented with a one-cycle valid pulse; a step that
// never answers aborts the job with a one-cycle timeout pulse.
//
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-high reset
//   run           - job request, accepted only while ready
//   run_data      - job input word, sampled on acceptance
//   ready         - sequencer idle
//   step_start    - one-hot start pulse to step i
//   step_in_data  - data to all steps (registered)
//   step_out_data - step i result in bits [i*DATA_W +: DATA_W]
//   step_done     - step i completion
//   result        - final chain output, held until the next success
//   result_valid  - one-cycle pulse, result updated
//   timeout_err   - one-cycle pulse, a step timed out
//   fail_idx      - index of the timed-out step, held until the next error
// ---------------------------------------------------------------------------
module step_sequencer
  import step_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int DATA_W    = STEP_DATA_W,
  parameter int TIMEOUT   = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              run,
  input  logic [DATA_W-1:0]                 run_data,
  output logic                              ready,
  output logic [NUM_STEPS-1:0]              step_start,
  output logic [DATA_W-1:0]                 step_in_data,
  input  logic [NUM_STEPS*DATA_W-1:0]       step_out_data,
  input  logic [NUM_STEPS-1:0]              step_done,
  output logic [DATA_W-1:0]                 result,
  output logic                              result_valid,
  output logic                              timeout_err,
  output logic [idx_width(NUM_STEPS)-1:0]   fail_idx
);

  localparam int IDX_W = idx_width(NUM_STEPS);

  step_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;

  logic [DATA_W-1:0] cur_slice;
  logic              cur_done;
  logic              last_step;
  logic              wd_expired;

  // Wait counter for the step currently being served. It is cleared during
  // ISSUE and only advances on WAIT cycles where the step stays silent.
  step_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == S_ISSUE),
    .en      ((state_q == S_WAIT) && !cur_done),
    .expired (wd_expired)
  );

  // Pick out the done bit and output word of the step at idx_q; every other
  // step's done is invisible to the rest of the logic.
  always_comb begin
    cur_slice = '0;
    cur_done  = 1'b0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_slice = step_out_data[i*DATA_W +: DATA_W];
        cur_done  = step_done[i];
      end
    end
  end

  assign last_step = (idx_q == IDX_W'(NUM_STEPS - 1));

  // State and datapath registers. Reset is asynchronous so a job is
  // abandoned immediately and the decoded start pulse drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      data_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      fail_idx_q     <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      data_q         <= data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
      fail_idx_q     <= fail_idx_d;
    end
  end

  // Next-state logic. done is only looked at in WAIT, so a done left over
  // from the previous step during ISSUE cannot advance the chain. A done on
  // the final allowed WAIT edge still counts as success.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cur_done) begin
          state_d = last_step ? S_IDLE : S_ISSUE;
        end else if (wd_expired) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates that go with each transition. Data is passed through
  // untouched; a timeout leaves data and result as they were.
  always_comb begin
    idx_d          = idx_q;
    data_d         = data_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_err_d  = 1'b0;
    fail_idx_d     = fail_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          data_d = run_data;
          idx_d  = '0;
        end
      end
      S_WAIT: begin
        if (cur_done) begin
          data_d = cur_slice;
          if (last_step) begin
            result_d       = cur_slice;
            result_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (wd_expired) begin
          timeout_err_d = 1'b1;
          fail_idx_d    = idx_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded straight from registered state and the data register.
  always_comb begin
    ready        = (state_q == S_IDLE);
    step_in_data = data_q;
    step_start   = '0;
    if (state_q == S_ISSUE) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        if (idx_q == IDX_W'(i)) step_start[i] = 1'b1;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;
  assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_step_sequencer
// Directed bench for step_sequencer with four behavioural +10 step
// responders. Each responder can answer immediately, after a programmable
// number of extra cycles, or never. Extra 'stray' done bits can be OR-ed
// onto the done bus to model misbehaving neighbours.
// ---------------------------------------------------------------------------
module tb_step_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  run_data;
  logic        ready;
  logic [3:0]  step_start;
  logic [7:0]  step_in_data;
  logic [31:0] step_out_data;
  logic [3:0]  step_done;
  logic [7:0]  result;
  logic        result_valid;
  logic        timeout_err;
  logic [1:0]  fail_idx;

  logic [3:0]  resp_done;
  logic [7:0]  resp_out [4];
  int          pend [4];
  int          delay [4];
  logic [3:0]  stray;

  int vectors;
  int miscompares;

  step_sequencer #(
    .NUM_STEPS (4),
    .DATA_W    (8),
    .TIMEOUT   (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .run_data      (run_data),
    .ready         (ready),
    .step_start    (step_start),
    .step_in_data  (step_in_data),
    .step_out_data (step_out_data),
    .step_done     (step_done),
    .result        (result),
    .result_valid  (result_valid),
    .timeout_err   (timeout_err),
    .fail_idx      (fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step responders: on the edge that sees start, latch in_data+10. With
  // delay 0 done is raised for the next cycle; with delay N it is raised N
  // edges later; a negative delay never answers. done is a one-cycle pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_done <= '0;
      for (int i = 0; i < 4; i++) begin
        resp_out[i] <= '0;
        pend[i]     <= -1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        resp_done[i] <= 1'b0;
        if (step_start[i]) begin
          resp_out[i] <= step_in_data + 8'd10;
          if (delay[i] == 0) resp_done[i] <= 1'b1;
          pend[i] <= (delay[i] > 0) ? delay[i] : -1;
        end else if (pend[i] > 0) begin
          if (pend[i] == 1) resp_done[i] <= 1'b1;
          pend[i] <= pend[i] - 1;
        end
      end
    end
  end

  assign step_out_data = {resp_out[3], resp_out[2], resp_out[1], resp_out[0]};
  assign step_done     = resp_done | stray;

  // Request a job with the given data; returns at the falling edge right
  // after the acceptance edge with run already dropped.
  task automatic do_run(input logic [7:0] d);
    @(negedge clk);
    run      = 1'b1;
    run_data = d;
    @(negedge clk);
    run      = 1'b0;
  endtask

  // Reset values, checked while reset is still asserted.
  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got=%0b exp=1", ready); end
    vectors++; if (step_start !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_start got=%b exp=0000", step_start); end
    vectors++; if (step_in_data !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_in_data got=%0d exp=0", step_in_data); end
    vectors++; if (result !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_result got=%0d exp=0", result); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rv got=%0b exp=0", result_valid); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_te got=%0b exp=0", timeout_err); end
    vectors++; if (fail_idx !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_fail_idx got=%0d exp=0", fail_idx); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Four single-cycle +10 steps: 5 -> 45, start pulses every second cycle.
  task automatic test_nominal();
    logic [3:0] exp_start;
    do_run(8'd5);
    for (int j = 0; j <= 9; j++) begin
      exp_start = '0;
      if ((j < 8) && (j % 2 == 0)) exp_start[j/2] = 1'b1;
      vectors++; if (step_start !== exp_start) begin miscompares++; $display("[TB] FAIL nom_start j=%0d got=%b exp=%b", j, step_start, exp_start); end
      if (exp_start != 4'b0000) begin
        vectors++; if (step_in_data !== 8'(5 + 10 * (j / 2))) begin miscompares++; $display("[TB] FAIL nom_in_data j=%0d got=%0d exp=%0d", j, step_in_data, 5 + 10 * (j / 2)); end
      end
      vectors++; if (result_valid !== (j == 8)) begin miscompares++; $display("[TB] FAIL nom_rv j=%0d got=%0b exp=%0b", j, result_valid, (j == 8)); end
      vectors++; if (ready !== (j >= 8)) begin miscompares++; $display("[TB] FAIL nom_ready j=%0d got=%0b exp=%0b", j, ready, (j >= 8)); end
      if (j == 8) begin
        vectors++; if (result !== 8'd45) begin miscompares++; $display("[TB] FAIL nom_result got=%0d exp=45", result); end
      end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL nom_te j=%0d got=%0b exp=0", j, timeout_err); end
      @(negedge clk);
    end
  endtask

  // Step 2 never answers: timeout after its 15th WAIT edge, result kept.
  task automatic test_timeout();
    delay[2] = -1;
    do_run(8'd5);
    for (int j = 0; j <= 21; j++) begin
      vectors++; if (timeout_err !== (j == 20)) begin miscompares++; $display("[TB] FAIL to_te j=%0d got=%0b exp=%0b", j, timeout_err, (j == 20)); end
      vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL to_rv j=%0d got=%0b exp=0", j, result_valid); end
      if (j == 19) begin
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL to_busy got=%0b exp=0", ready); end
      end
      if (j == 20) begin
        vectors++; if (fail_idx !== 2'd2) begin miscompares++; $display("[TB] FAIL to_fail_idx got=%0d exp=2", fail_idx); end
        vectors++; if (result !== 8'd45) begin miscompares++; $display("[TB] FAIL to_result_kept got=%0d exp=45", result); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL to_ready got=%0b exp=1", ready); end
        vectors++; if (step_in_data !== 8'd25) begin miscompares++; $display("[TB] FAIL to_data_kept got=%0d exp=25", step_in_data); end
      end
      @(negedge clk);
    end
    delay[2] = 0;
  endtask

  // run held high across two jobs: the second starts one edge after the
  // first result pulse, and the held request does not restart job one.
  task automatic test_back_to_back();
    @(negedge clk);
    run      = 1'b1;
    run_data = 8'd5;
    @(negedge clk);
    for (int j = 0; j <= 18; j++) begin
      vectors++; if (result_valid !== ((j == 8) || (j == 17))) begin miscompares++; $display("[TB] FAIL b2b_rv j=%0d got=%0b", j, result_valid); end
      if (j == 2) begin
        vectors++; if (step_start !== 4'b0010) begin miscompares++; $display("[TB] FAIL b2b_busy_start got=%b exp=0010", step_start); end
        vectors++; if (step_in_data !== 8'd15) begin miscompares++; $display("[TB] FAIL b2b_busy_data got=%0d exp=15", step_in_data); end
      end
      if (j == 8) begin
        vectors++; if (result !== 8'd45) begin miscompares++; $display("[TB] FAIL b2b_result1 got=%0d exp=45", result); end
        run_data = 8'd20;
      end
      if (j == 9) begin
        vectors++; if (step_start !== 4'b0001) begin miscompares++; $display("[TB] FAIL b2b_accept got=%b exp=0001", step_start); end
        vectors++; if (step_in_data !== 8'd20) begin miscompares++; $display("[TB] FAIL b2b_data2 got=%0d exp=20", step_in_data); end
        run = 1'b0;
      end
      if (j == 17) begin
        vectors++; if (result !== 8'd60) begin miscompares++; $display("[TB] FAIL b2b_result2 got=%0d exp=60", result); end
      end
      if (j == 18) begin
        vectors++; if ((ready !== 1'b1) || (step_start !== 4'b0000)) begin miscompares++; $display("[TB] FAIL b2b_idle ready=%0b start=%b exp ready=1 start=0000", ready, step_start); end
      end
      @(negedge clk);
    end
  endtask

  // Stray done[3] while step 0 (delayed by two cycles) is pending, and
  // done[0] held through step 1 ISSUE/WAIT; neither may move the chain.
  task automatic test_stray_done();
    logic [3:0] exp_start;
    delay[0] = 2;
    do_run(8'd5);
    stray[3] = 1'b1;
    for (int j = 0; j <= 11; j++) begin
      case (j)
        0:       exp_start = 4'b0001;
        4:       exp_start = 4'b0010;
        6:       exp_start = 4'b0100;
        8:       exp_start = 4'b1000;
        default: exp_start = 4'b0000;
      endcase
      vectors++; if (step_start !== exp_start) begin miscompares++; $display("[TB] FAIL stray_start j=%0d got=%b exp=%b", j, step_start, exp_start); end
      vectors++; if (result_valid !== (j == 10)) begin miscompares++; $display("[TB] FAIL stray_rv j=%0d got=%0b exp=%0b", j, result_valid, (j == 10)); end
      if (j == 4) begin
        vectors++; if (step_in_data !== 8'd15) begin miscompares++; $display("[TB] FAIL stray_data1 got=%0d exp=15", step_in_data); end
      end
      if (j == 10) begin
        vectors++; if (result !== 8'd45) begin miscompares++; $display("[TB] FAIL stray_result got=%0d exp=45", result); end
      end
      if (j == 3) stray[3] = 1'b0;
      if (j == 4) stray[0] = 1'b1;
      if (j == 6) stray[0] = 1'b0;
      @(negedge clk);
    end
    delay[0] = 0;
  endtask

  // Step 1 answers on its 14th WAIT edge: no error, result 13 cycles late.
  task automatic test_slow_step();
    delay[1] = 13;
    do_run(8'd5);
    for (int j = 0; j <= 22; j++) begin
      vectors++; if (result_valid !== (j == 21)) begin miscompares++; $display("[TB] FAIL slow_rv j=%0d got=%0b exp=%0b", j, result_valid, (j == 21)); end
      vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL slow_te j=%0d got=%0b exp=0", j, timeout_err); end
      if (j == 21) begin
        vectors++; if (result !== 8'd45) begin miscompares++; $display("[TB] FAIL slow_result got=%0d exp=45", result); end
      end
      @(negedge clk);
    end
    delay[1] = 0;
  endtask

  // Asynchronous reset in the middle of step 1 WAIT, then a clean job.
  task automatic test_reset_midjob();
    delay[1] = 5;
    do_run(8'd5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy got=%0b exp=0", ready); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_async_ready got=%0b exp=1", ready); end
    vectors++; if (step_start !== 4'b0000) begin miscompares++; $display("[TB] FAIL mid_async_start got=%b exp=0000", step_start); end
    vectors++; if (step_in_data !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_async_data got=%0d exp=0", step_in_data); end
    vectors++; if (result !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_async_result got=%0d exp=0", result); end
    vectors++; if (fail_idx !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_async_fail_idx got=%0d exp=0", fail_idx); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++; if ((result_valid !== 1'b0) || (timeout_err !== 1'b0)) begin miscompares++; $display("[TB] FAIL mid_no_pulse rv=%0b te=%0b exp 0/0", result_valid, timeout_err); end
    end
    rst      = 1'b0;
    delay[1] = 0;
    do_run(8'd5);
    for (int j = 0; j <= 9; j++) begin
      vectors++; if (result_valid !== (j == 8)) begin miscompares++; $display("[TB] FAIL mid_fresh_rv j=%0d got=%0b exp=%0b", j, result_valid, (j == 8)); end
      if (j == 8) begin
        vectors++; if (result !== 8'd45) begin miscompares++; $display("[TB] FAIL mid_fresh_result got=%0d exp=45", result); end
      end
      @(negedge clk);
    end
  endtask

  // Scenario sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    run         = 1'b0;
    run_data    = '0;
    stray       = '0;
    for (int i = 0; i < 4; i++) delay[i] = 0;
    $display("[TB] step_sequencer bench start");
    test_reset();
    test_nominal();
    test_timeout();
    test_back_to_back();
    test_stray_done();
    test_slow_step();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
